// File: rtl/pcpi_pkg.sv
// Shared definitions for the PCPI multiplier arbiter: RV32M opcode fields,
// FSM state encoding and the MUL-family instruction decoder.
package pcpi_pkg;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    // funct3[2]==0 selects MUL/MULH/MULHSU/MULHU; DIV/REM have funct3[2]==1.
    function automatic logic is_mul_insn(input logic [31:0] insn);
        return (insn[6:0] == OPCODE_OP) && (insn[31:25] == FUNCT7_MULDIV) && !insn[14];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first asserted request at or after
// ptr_i (wrapping) wins, reported as one-hot grant plus binary index.
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [PW-1:0] idx_o,
    output logic          any_o
);

    always_comb begin
        int          j;
        logic [PW-1:0] jj;
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        j       = 0;
        jj      = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_i) + k;
            if (j >= N) j = j - N;
            jj = PW'(j);
            if (!any_o && req_i[jj]) begin
                any_o       = 1'b1;
                grant_o[jj] = 1'b1;
                idx_o       = jj;
            end
        end
    end

endmodule

// File: rtl/pcpi_mul_arbiter.sv
// Shares one PCPI multiplier between NUM_REQ PCPI requesters: decodes MUL-family
// instructions, arbitrates round-robin, drives the multiplier and routes results back.
module pcpi_mul_arbiter
    import pcpi_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*32-1:0]   req_insn,
    input  logic [NUM_REQ*32-1:0]   req_rs1,
    input  logic [NUM_REQ*32-1:0]   req_rs2,
    output logic [NUM_REQ-1:0]      req_wr,
    output logic [NUM_REQ*32-1:0]   req_rd,
    output logic [NUM_REQ-1:0]      req_wait,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    mul_valid,
    output logic [31:0]             mul_insn,
    output logic [31:0]             mul_rs1,
    output logic [31:0]             mul_rs2,
    input  logic                    mul_wr,
    input  logic [31:0]             mul_rd,
    input  logic                    mul_wait,
    input  logic                    mul_ready,
    output logic                    err_timeout
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [NUM_REQ-1:0][31:0] insn_v, rs1_v, rs2_v;
    assign insn_v = req_insn;
    assign rs1_v  = req_rs1;
    assign rs2_v  = req_rs2;

    state_e                   state_q;
    logic [PW-1:0]            ptr_q, g_q;
    logic [TW-1:0]            timer_q;
    logic                     abandon_q;
    logic [NUM_REQ-1:0]       done_q;
    logic                     mul_valid_q;
    logic [31:0]              mul_insn_q, mul_rs1_q, mul_rs2_q;
    logic [NUM_REQ-1:0]       req_wr_q, req_wait_q, req_ready_q;
    logic [NUM_REQ-1:0][31:0] req_rd_q;
    logic                     err_q;

    // The multiplier's own wait is informational only; our req_wait covers the core.
    logic unused_mul_wait;
    assign unused_mul_wait = mul_wait;

    logic [NUM_REQ-1:0] claim;
    always_comb begin
        claim = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            claim[i] = req_valid[i] & is_mul_insn(insn_v[i]) & ~done_q[i];
        end
    end

    logic [NUM_REQ-1:0] pick_grant;
    logic [PW-1:0]      pick_idx;
    logic               pick_any;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req_i   (claim),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    logic [31:0] sel_insn, sel_rs1, sel_rs2;
    always_comb begin
        sel_insn = '0;
        sel_rs1  = '0;
        sel_rs2  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) begin
                sel_insn = insn_v[i];
                sel_rs1  = rs1_v[i];
                sel_rs2  = rs2_v[i];
            end
        end
    end

    // Result is delivered only if the grantee has held valid for the whole op.
    logic          keep;
    logic [PW-1:0] next_ptr;
    assign keep     = !abandon_q && req_valid[g_q];
    assign next_ptr = (g_q == PW'(NUM_REQ - 1)) ? '0 : g_q + PW'(1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            g_q         <= '0;
            timer_q     <= '0;
            abandon_q   <= 1'b0;
            done_q      <= '0;
            mul_valid_q <= 1'b0;
            mul_insn_q  <= '0;
            mul_rs1_q   <= '0;
            mul_rs2_q   <= '0;
            req_wr_q    <= '0;
            req_wait_q  <= '0;
            req_ready_q <= '0;
            req_rd_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            req_ready_q <= '0;
            req_wr_q    <= '0;
            req_wait_q  <= claim;
            done_q      <= done_q & req_valid;
            case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        g_q         <= pick_idx;
                        mul_insn_q  <= sel_insn;
                        mul_rs1_q   <= sel_rs1;
                        mul_rs2_q   <= sel_rs2;
                        mul_valid_q <= 1'b1;
                        timer_q     <= '0;
                        abandon_q   <= 1'b0;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!req_valid[g_q]) abandon_q <= 1'b1;
                    if (mul_ready) begin
                        mul_valid_q <= 1'b0;
                        ptr_q       <= next_ptr;
                        state_q     <= ST_GAP;
                        if (keep) begin
                            req_ready_q[g_q] <= 1'b1;
                            req_wr_q[g_q]    <= mul_wr;
                            req_rd_q[g_q]    <= mul_rd;
                            done_q[g_q]      <= 1'b1;
                            req_wait_q[g_q]  <= 1'b0;
                        end
                    end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        // Abort: release the core with wr=0 rather than let it hang.
                        mul_valid_q <= 1'b0;
                        err_q       <= 1'b1;
                        ptr_q       <= next_ptr;
                        state_q     <= ST_GAP;
                        if (keep) begin
                            req_ready_q[g_q] <= 1'b1;
                            done_q[g_q]      <= 1'b1;
                            req_wait_q[g_q]  <= 1'b0;
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                ST_GAP:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mul_valid   = mul_valid_q;
    assign mul_insn    = mul_insn_q;
    assign mul_rs1     = mul_rs1_q;
    assign mul_rs2     = mul_rs2_q;
    assign req_wr      = req_wr_q;
    assign req_rd      = req_rd_q;
    assign req_wait    = req_wait_q;
    assign req_ready   = req_ready_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_pcpi_mul_arbiter.sv
// Directed bench for pcpi_mul_arbiter with a behavioural PCPI multiplier and
// per-requester expected-result queues.
module tb_pcpi_mul_arbiter;

    localparam int NREQ = 2;
    localparam int TMO  = 64;

    logic                  clk;
    logic                  resetn;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*32-1:0]    req_insn, req_rs1, req_rs2;
    logic [NREQ-1:0]       req_wr, req_wait, req_ready;
    logic [NREQ*32-1:0]    req_rd;
    logic                  mul_valid;
    logic [31:0]           mul_insn, mul_rs1, mul_rs2;
    logic                  mul_wr, mul_wait, mul_ready;
    logic [31:0]           mul_rd;
    logic                  err_timeout;

    logic        val_a [NREQ];
    logic [31:0] insn_a[NREQ];
    logic [31:0] rs1_a [NREQ];
    logic [31:0] rs2_a [NREQ];
    assign req_valid = {val_a[1], val_a[0]};
    assign req_insn  = {insn_a[1], insn_a[0]};
    assign req_rs1   = {rs1_a[1], rs1_a[0]};
    assign req_rs2   = {rs2_a[1], rs2_a[0]};

    pcpi_mul_arbiter #(.NUM_REQ(NREQ), .TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req_valid   (req_valid),
        .req_insn    (req_insn),
        .req_rs1     (req_rs1),
        .req_rs2     (req_rs2),
        .req_wr      (req_wr),
        .req_rd      (req_rd),
        .req_wait    (req_wait),
        .req_ready   (req_ready),
        .mul_valid   (mul_valid),
        .mul_insn    (mul_insn),
        .mul_rs1     (mul_rs1),
        .mul_rs2     (mul_rs2),
        .mul_wr      (mul_wr),
        .mul_rd      (mul_rd),
        .mul_wait    (mul_wait),
        .mul_ready   (mul_ready),
        .err_timeout (err_timeout)
    );

    int checks   = 0;
    int failures = 0;
    int model_lat   = 2;
    bit never_ready = 1'b0;

    // Entry: {check_rd, wr, rd}
    logic [33:0] exp_q0[$];
    logic [33:0] exp_q1[$];
    int          exp_order[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_insn(input logic [2:0] funct3);
        return {7'b0000001, 5'd2, 5'd1, funct3, 5'd3, 7'b0110011};
    endfunction

    function automatic logic [31:0] mul_ref(input logic [31:0] insn, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (insn[13:12])
            2'b01:   p = sa * sb;
            2'b10:   p = sa * ub;
            default: p = ua * ub;
        endcase
        return (insn[13:12] == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Behavioural multiplier: ready one cycle after model_lat cycles of valid.
    initial begin
        int lat_cnt;
        lat_cnt   = 0;
        mul_ready = 1'b0;
        mul_wr    = 1'b0;
        mul_rd    = '0;
        mul_wait  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            mul_ready = 1'b0;
            mul_wr    = 1'b0;
            if (mul_valid && !never_ready) begin
                if (lat_cnt >= model_lat) begin
                    mul_ready = 1'b1;
                    mul_wr    = 1'b1;
                    mul_rd    = mul_ref(mul_insn, mul_rs1, mul_rs2);
                    lat_cnt   = 0;
                end else begin
                    lat_cnt++;
                end
            end else begin
                lat_cnt = 0;
            end
            mul_wait = mul_valid & ~mul_ready;
        end
    end

    // Scoreboard: every req_ready pulse pops that requester's queue and the grant order.
    initial begin
        logic [33:0] e;
        bit gap_pending;
        gap_pending = 1'b0;
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (gap_pending) begin
                    chk("gap_cycle_mul_valid", mul_valid, 0);
                    gap_pending = 1'b0;
                end
                for (int i = 0; i < NREQ; i++) begin
                    if (req_ready[i]) begin
                        chk("ready_expected", ((i == 0) ? exp_q0.size() : exp_q1.size()) != 0, 1);
                        chk("ready_drops_mul_valid", mul_valid, 0);
                        gap_pending = 1'b1;
                        if (exp_order.size() != 0) chk("grant_order", i, exp_order.pop_front());
                        if ((i == 0 && exp_q0.size() != 0) || (i == 1 && exp_q1.size() != 0)) begin
                            e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                            chk("req_wr", req_wr[i], e[32]);
                            if (e[33]) chk("req_rd", req_rd[32*i +: 32], e[31:0]);
                        end
                    end
                end
            end
        end
    end

    task automatic req_txn(input int i, input logic [31:0] insn, input logic [31:0] a,
                           input logic [31:0] b, input logic chk_rd, input logic wr,
                           input logic [31:0] rd);
        bit got;
        if (i == 0) exp_q0.push_back({chk_rd, wr, rd});
        else        exp_q1.push_back({chk_rd, wr, rd});
        insn_a[i] = insn;
        rs1_a[i]  = a;
        rs2_a[i]  = b;
        val_a[i]  = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge clk);
            if (req_ready[i]) got = 1'b1;
        end
        chk("ready_within_bound", got, 1);
        val_a[i] = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        for (int i = 0; i < NREQ; i++) val_a[i] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mul_valid", mul_valid, 0);
        chk("rst_mul_insn", mul_insn, 0);
        chk("rst_req_wait", req_wait, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_req_wr", req_wr, 0);
        chk("rst_req_rd", req_rd, 0);
        chk("rst_err_timeout", err_timeout, 0);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        bit got;
        int cnt, bad;
        resetn = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            val_a[i] = 1'b0; insn_a[i] = '0; rs1_a[i] = '0; rs2_a[i] = '0;
        end
        do_reset();

        // 1: single MUL 3*7, latency and one-cycle ready
        exp_q0.push_back({1'b1, 1'b1, 32'd21});
        exp_order.push_back(0);
        insn_a[0] = mk_insn(3'b000); rs1_a[0] = 32'd3; rs2_a[0] = 32'd7; val_a[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t1_mul_valid_latency", mul_valid, 1);
        chk("t1_mul_insn", mul_insn, mk_insn(3'b000));
        chk("t1_mul_rs1", mul_rs1, 32'd3);
        chk("t1_mul_rs2", mul_rs2, 32'd7);
        chk("t1_req_wait", req_wait[0], 1);
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            if (req_ready[0]) got = 1'b1;
            else @(negedge clk);
        end
        chk("t1_ready_seen", got, 1);
        chk("t1_wait_dropped", req_wait[0], 0);
        @(negedge clk);
        chk("t1_ready_one_cycle", req_ready[0], 0);
        chk("t1_rd_held", req_rd[31:0], 32'd21);
        val_a[0] = 1'b0;
        @(negedge clk);

        // 2: simultaneous claims from a fresh pointer
        do_reset();
        exp_order.push_back(0);
        exp_order.push_back(1);
        bad = 0;
        fork
            req_txn(0, mk_insn(3'b001), -32'sd10, -32'sd4, 1'b1, 1'b1, 32'h0000_0000);
            req_txn(1, mk_insn(3'b011), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'hFFFF_FFFE);
            begin
                for (int c = 0; c < 300; c++) begin
                    @(negedge clk);
                    if (req_ready[1]) break;
                    if (req_wait[1] !== 1'b1) bad++;
                end
            end
        join
        chk("t2_wait1_held", bad, 0);

        // 3: four back-to-back MULs per requester alternate grants
        for (int k = 0; k < 8; k++) exp_order.push_back(k % 2);
        fork
            begin
                logic [31:0] a, b;
                for (int k = 0; k < 4; k++) begin
                    a = $urandom; b = $urandom_range(1, 65535);
                    req_txn(0, mk_insn(3'b000), a, b, 1'b1, 1'b1, a * b);
                end
            end
            begin
                logic [31:0] a, b;
                for (int k = 0; k < 4; k++) begin
                    a = $urandom; b = $urandom;
                    req_txn(1, mk_insn(3'b000), a, b, 1'b1, 1'b1, a * b);
                end
            end
        join
        chk("t3_order_drained", exp_order.size(), 0);

        // 4: DIV is not claimed
        insn_a[1] = mk_insn(3'b100); rs1_a[1] = 32'd100; rs2_a[1] = 32'd5; val_a[1] = 1'b1;
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (req_wait[1] !== 1'b0 || req_ready[1] !== 1'b0 || mul_valid !== 1'b0) bad++;
        end
        chk("t4_div_ignored", bad, 0);
        val_a[1] = 1'b0;
        @(negedge clk);

        // 5: timeout abort, then a normal MULHSU
        never_ready = 1'b1;
        exp_order.push_back(0);
        cnt = 0;
        fork
            req_txn(0, mk_insn(3'b000), 32'd5, 32'd6, 1'b0, 1'b0, 32'h0);
            begin
                for (int c = 0; c < 400; c++) begin
                    @(negedge clk);
                    if (req_ready[0]) break;
                    if (mul_valid) cnt++;
                end
            end
        join
        chk("t5_issue_cycles", cnt, TMO);
        chk("t5_err_timeout", err_timeout, 1);
        never_ready = 1'b0;
        exp_order.push_back(0);
        req_txn(0, mk_insn(3'b010), -32'sd10, 32'd4, 1'b1, 1'b1, 32'hFFFF_FFFF);
        chk("t5_err_sticky", err_timeout, 1);

        // 6: asynchronous reset during ISSUE, then a fresh MUL
        never_ready = 1'b1;
        insn_a[0] = mk_insn(3'b000); rs1_a[0] = 32'd1000; rs2_a[0] = 32'd1000; val_a[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t6_in_issue", mul_valid, 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("t6_async_mul_valid", mul_valid, 0);
        chk("t6_async_mul_insn", mul_insn, 0);
        chk("t6_async_req_wait", req_wait, 0);
        chk("t6_async_req_rd", req_rd, 0);
        chk("t6_async_err", err_timeout, 0);
        val_a[0] = 1'b0;
        never_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        exp_order.push_back(0);
        req_txn(0, mk_insn(3'b000), 32'd1000, 32'd1000, 1'b1, 1'b1, 32'h000F_4240);
        chk("t6_err_clear", err_timeout, 0);
        chk("sb_q0_drained", exp_q0.size(), 0);
        chk("sb_q1_drained", exp_q1.size(), 0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
